// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state type and digit-blanking helper for the scan controller
package seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         NUM_DIGITS = 4;

    typedef enum logic {
        OFF  = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // True when digit i is zero and no higher digit is non-zero; digit 0 is never blanked.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
        logic blank;
        case (i)
            2'd3:    blank = (v[15:12] == 4'h0);
            2'd2:    blank = (v[15:8] == 8'h00);
            2'd1:    blank = (v[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/BCDToLED.sv
// rtl/BCDToLED.sv - nibble to active-low seven-segment decoder (gfedcba), hex for 10-15
module BCDToLED (
    input  logic [3:0] x,
    output logic [6:0] seg,
    output logic [3:0] an
);

    assign an = 4'b1110;

    always_comb begin
        seg = 7'b1111111;
        case (x)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller with frame-aligned value commit
// Optional leading-zero blanking is enabled by defining SCAN_LZB_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        pending,
    output logic        frame_done,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int              CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       disp_q, disp_d;
    logic [15:0]       pend_q, pend_d;
    logic              pending_q, pending_d;
    logic              frame_done_q, frame_done_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    logic              tick;
    logic              boundary;
    logic [3:0]        nibble_sel;
    logic [6:0]        dec_seg;
    logic [3:0]        dec_an_unused;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (enable)  state_d = SCAN;
            SCAN:    if (!enable) state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    // Prescaler, digit index and the pending/display buffers
    always_comb begin
        tick     = (state_q == SCAN) && (tick_cnt_q == CNT_LAST);
        boundary = tick && (idx_q == 2'd3);

        tick_cnt_d = '0;
        idx_d      = 2'd0;
        if (state_q == SCAN && state_d == SCAN) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            idx_d      = tick ? idx_q + 2'd1 : idx_q;
        end

        disp_d       = disp_q;
        pend_d       = pend_q;
        pending_d    = pending_q;
        frame_done_d = boundary;

        if (boundary) begin
            // A load landing on the boundary bypasses the pending buffer.
            if (load) begin
                disp_d = value_in;
                pend_d = value_in;
            end else if (pending_q) begin
                disp_d = pend_q;
            end
            pending_d = 1'b0;
        end else begin
            if (state_q == OFF && pending_q) begin
                disp_d    = pend_q;
                pending_d = 1'b0;
            end
            if (load) begin
                pend_d    = value_in;
                pending_d = 1'b1;
            end
        end
    end

    // The decoder sees the digit that will be on the bus after this edge.
    assign nibble_sel = disp_d[{idx_d, 2'b00} +: 4];

    BCDToLED u_dec (
        .x   (nibble_sel),
        .seg (dec_seg),
        .an  (dec_an_unused)
    );

    // Output logic
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (state_d == SCAN) begin
            an_d  = AN_OFF ^ (4'b0001 << idx_d);
            seg_d = dec_seg;
`ifdef SCAN_LZB_EN
            if (lz_blank(disp_d, idx_d)) begin
                an_d = AN_OFF;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl (TICK_DIV=4)
module tb_seg_scan_ctrl;

    localparam int NVEC = 96;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        pend;
        logic        fd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic        pending;
    logic        frame_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;

    logic [6:0] dec_tab [16];
    vec_t       vecs [NVEC];

    seg_scan_ctrl #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value_in   (value_in),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic ld, input logic [15:0] val);
        enable   = en;
        load     = ld;
        value_in = val;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_an(input logic [15:0] d, input int slot);
        logic [3:0] a;
        a = 4'b1111 ^ (4'b0001 << slot);
`ifdef SCAN_LZB_EN
        if (slot == 1 && d[15:4] == 12'h000) a = 4'b1111;
        if (slot == 2 && d[15:8] == 8'h00)   a = 4'b1111;
        if (slot == 3 && d[15:12] == 4'h0)   a = 4'b1111;
`endif
        return a;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int slot);
        logic [3:0] n;
        n = d[slot*4 +: 4];
        return dec_tab[n];
    endfunction

    initial begin
        logic [15:0] d;
        int slot;

        dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
        dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
        dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
        dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
        dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
        dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001;
        dec_tab[14] = 7'b0000110; dec_tab[15] = 7'b0001110;

        // Frames of 16 cycles: 1234 loaded mid-frame, 1111 then 5678, 9ABC on a boundary.
        for (int k = 0; k < NVEC; k++) begin
            vecs[k].en = 1'b1;
            vecs[k].ld = (k == 37) || (k == 50) || (k == 55) || (k == 80);
            case (k)
                37:      vecs[k].val = 16'h1234;
                50:      vecs[k].val = 16'h1111;
                55:      vecs[k].val = 16'h5678;
                80:      vecs[k].val = 16'h9ABC;
                default: vecs[k].val = 16'hDEAD;
            endcase
            if (k < 48)      d = 16'h0000;
            else if (k < 64) d = 16'h1234;
            else if (k < 80) d = 16'h5678;
            else             d = 16'h9ABC;
            slot = (k / 4) % 4;
            vecs[k].an   = exp_an(d, slot);
            vecs[k].seg  = exp_seg(d, slot);
            vecs[k].pend = (k >= 37 && k < 48) || (k >= 50 && k < 64);
            vecs[k].fd   = (k > 0) && (k % 16 == 0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        step(1'b0, 1'b0, 16'h0000);
        chk("off_an", 32'(an), 32'hF);

        for (int k = 0; k < NVEC; k++) begin
            step(vecs[k].en, vecs[k].ld, vecs[k].val);
            chk($sformatf("v%0d_an", k), 32'(an), 32'(vecs[k].an));
            chk($sformatf("v%0d_seg", k), 32'(seg), 32'(vecs[k].seg));
            chk($sformatf("v%0d_pending", k), 32'(pending), 32'(vecs[k].pend));
            chk($sformatf("v%0d_frame_done", k), 32'(frame_done), 32'(vecs[k].fd));
        end

        // Drop enable in slot 2, load while off, re-enable.
        for (int k = 96; k < 105; k++) step(1'b1, 1'b0, 16'hDEAD);
        step(1'b0, 1'b0, 16'hDEAD);
        chk("drop_an", 32'(an), 32'hF);
        chk("drop_seg", 32'(seg), 32'h7F);
        step(1'b0, 1'b1, 16'h0042);
        chk("off_load_pending", 32'(pending), 32'h1);
        chk("off_load_an", 32'(an), 32'hF);
        step(1'b0, 1'b0, 16'hDEAD);
        chk("off_commit_pending", 32'(pending), 32'h0);
        step(1'b1, 1'b0, 16'hDEAD);
        chk("reen_an", 32'(an), 32'(exp_an(16'h0042, 0)));
        chk("reen_seg", 32'(seg), 32'(dec_tab[2]));
        repeat (4) step(1'b1, 1'b0, 16'hDEAD);
        chk("reen_slot1_an", 32'(an), 32'(exp_an(16'h0042, 1)));
        chk("reen_slot1_seg", 32'(seg), 32'(dec_tab[4]));
        repeat (4) step(1'b1, 1'b0, 16'hDEAD);
        chk("reen_slot2_an", 32'(an), 32'(exp_an(16'h0042, 2)));
        repeat (4) step(1'b1, 1'b0, 16'hDEAD);
        chk("reen_slot3_an", 32'(an), 32'(exp_an(16'h0042, 3)));

        // Reset in the middle of a frame with a value pending.
        step(1'b1, 1'b1, 16'h1357);
        chk("pre_reset_pending", 32'(pending), 32'h1);
        enable = 1'b0;
        reset  = 1'b1;
        #2;
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_seg", 32'(seg), 32'h7F);
        chk("midreset_pending", 32'(pending), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 16'hDEAD);
        chk("post_reset_an", 32'(an), 32'hE);
        chk("post_reset_seg", 32'(seg), 32'(dec_tab[0]));
        repeat (4) step(1'b1, 1'b0, 16'hDEAD);
        chk("post_reset_slot1_an", 32'(an), 32'(exp_an(16'h0000, 1)));
        chk("post_reset_slot1_seg", 32'(seg), 32'(dec_tab[0]));
        chk("post_reset_pending", 32'(pending), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
